// File: rtl/pe_phase_seq_pkg.sv
// rtl/pe_phase_seq_pkg.sv - shared phase encodings and default phase counts for pe_phase_seq
package pe_phase_seq_pkg;

    // Phase state encoding; the values are shared with the PE datapath decode.
    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LOAD     = 3'd1,
        COMPUTE  = 3'd2,
        TRANSMIT = 3'd3,
        SHIFT    = 3'd4,
        OUTPUT   = 3'd5
    } phase_e;

    // Default phase counts, loaded into the config registers on reset.
    localparam int PE_DEF_LOAD_NUM = 32;
    localparam int PE_DEF_INST_NUM = 20;
    localparam int PE_DEF_TX_NUM   = 4;
    localparam int PE_DEF_REG_NUM  = 16;
    localparam int PE_DEF_OUT_NUM  = 4;
    localparam int PE_DEF_ITER_NUM = 4;

endpackage

// File: rtl/pe_phase_seq_phase_counter.sv
// rtl/pe_phase_seq_phase_counter.sv - W-bit phase counter with enable, clear and terminal-count compare
// Ports: clk, rst (sync, active-high); clr_i forces zero; en_i advances the count;
//        last_i is the programmed count-1; cnt_o current count; tc_o high when cnt_o == last_i.
module phase_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr_i,
    input  logic         en_i,
    input  logic [W-1:0] last_i,
    output logic [W-1:0] cnt_o,
    output logic         tc_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    assign tc_o  = (cnt_q == last_i);
    assign cnt_o = cnt_q;

    // Returning to zero on the terminal beat leaves the counter ready for the
    // next visit to the same phase without a separate clear.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = tc_o ? '0 : cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/pe_phase_seq.sv
// rtl/pe_phase_seq.sv - runtime-configurable PE phase sequencer (LOAD/COMPUTE/TRANSMIT/SHIFT/OUTPUT)
// Ports: clk, rst (sync, active-high);
//        cfg_v + cfg_*_num write the per-run counts (IDLE only), cfg_err flags a rejected write;
//        start/abort control a run; din_pe_v counts LOAD beats; out_rdy accepts OUTPUT beats;
//        busy and load_v/cmpt_v/tx_v/shift_v/output_v decode the phase; inst_addr drives IMEM;
//        iter_cnt counts completed iterations; done pulses when a run completes normally.
module pe_phase_seq
    import pe_phase_seq_pkg::*;
#(
    parameter int CNT_W        = 8,
    parameter int IM_ADDR_W    = 8,
    parameter int DEF_LOAD_NUM = PE_DEF_LOAD_NUM,
    parameter int DEF_INST_NUM = PE_DEF_INST_NUM,
    parameter int DEF_TX_NUM   = PE_DEF_TX_NUM,
    parameter int DEF_REG_NUM  = PE_DEF_REG_NUM,
    parameter int DEF_OUT_NUM  = PE_DEF_OUT_NUM,
    parameter int DEF_ITER_NUM = PE_DEF_ITER_NUM
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cfg_v,
    input  logic [CNT_W-1:0]     cfg_load_num,
    input  logic [IM_ADDR_W-1:0] cfg_inst_num,
    input  logic [CNT_W-1:0]     cfg_tx_num,
    input  logic [CNT_W-1:0]     cfg_reg_num,
    input  logic [CNT_W-1:0]     cfg_out_num,
    input  logic [CNT_W-1:0]     cfg_iter_num,
    output logic                 cfg_err,
    input  logic                 start,
    input  logic                 abort,
    input  logic                 din_pe_v,
    input  logic                 out_rdy,
    output logic                 busy,
    output logic                 load_v,
    output logic                 cmpt_v,
    output logic                 tx_v,
    output logic                 shift_v,
    output logic                 output_v,
    output logic [IM_ADDR_W-1:0] inst_addr,
    output logic [CNT_W-1:0]     iter_cnt,
    output logic                 done
);

    phase_e state_q, state_d;

    logic [CNT_W-1:0]     load_num_q, load_num_d;
    logic [IM_ADDR_W-1:0] inst_num_q, inst_num_d;
    logic [CNT_W-1:0]     tx_num_q,   tx_num_d;
    logic [CNT_W-1:0]     reg_num_q,  reg_num_d;
    logic [CNT_W-1:0]     out_num_q,  out_num_d;
    logic [CNT_W-1:0]     iter_num_q, iter_num_d;
    logic                 cfg_err_q,  cfg_err_d;
    logic                 done_q,     done_d;

    logic cfg_wr;
    logic cfg_bad;
    logic cnt_clr;
    logic iter_inc;
    logic load_tc, inst_tc, tx_tc, sh_tc, out_tc, iter_tc;

    logic [CNT_W-1:0] load_cnt_unused;
    logic [CNT_W-1:0] tx_cnt_unused;
    logic [CNT_W-1:0] sh_cnt_unused;
    logic [CNT_W-1:0] out_cnt_unused;

    // ------------------------------------------------------------------
    // Config registers: writable only while idle and not starting a run.
    // ------------------------------------------------------------------
    assign cfg_wr  = (state_q == IDLE) && cfg_v && !start;
    assign cfg_bad = (cfg_inst_num == '0) || (cfg_iter_num == '0) || (cfg_out_num == '0);

    always_comb begin
        load_num_d = load_num_q;
        inst_num_d = inst_num_q;
        tx_num_d   = tx_num_q;
        reg_num_d  = reg_num_q;
        out_num_d  = out_num_q;
        iter_num_d = iter_num_q;
        cfg_err_d  = cfg_err_q;
        if (cfg_wr) begin
            if (cfg_bad) begin
                cfg_err_d = 1'b1;
            end else begin
                load_num_d = cfg_load_num;
                inst_num_d = cfg_inst_num;
                tx_num_d   = cfg_tx_num;
                reg_num_d  = cfg_reg_num;
                out_num_d  = cfg_out_num;
                iter_num_d = cfg_iter_num;
                cfg_err_d  = 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Phase counters. All of them are cleared whenever the next state is
    // IDLE, which covers abort and normal completion alike.
    // ------------------------------------------------------------------
    assign cnt_clr = (state_d == IDLE);

    phase_counter #(.W(CNT_W)) u_load_cnt (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (cnt_clr),
        .en_i   ((state_q == LOAD) && din_pe_v),
        .last_i (load_num_q - CNT_W'(1)),
        .cnt_o  (load_cnt_unused),
        .tc_o   (load_tc)
    );

    // The COMPUTE count doubles as the instruction address.
    phase_counter #(.W(IM_ADDR_W)) u_inst_cnt (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (cnt_clr),
        .en_i   (state_q == COMPUTE),
        .last_i (inst_num_q - IM_ADDR_W'(1)),
        .cnt_o  (inst_addr),
        .tc_o   (inst_tc)
    );

    phase_counter #(.W(CNT_W)) u_tx_cnt (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (cnt_clr),
        .en_i   (state_q == TRANSMIT),
        .last_i (tx_num_q - CNT_W'(1)),
        .cnt_o  (tx_cnt_unused),
        .tc_o   (tx_tc)
    );

    phase_counter #(.W(CNT_W)) u_sh_cnt (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (cnt_clr),
        .en_i   (state_q == SHIFT),
        .last_i (reg_num_q - CNT_W'(1)),
        .cnt_o  (sh_cnt_unused),
        .tc_o   (sh_tc)
    );

    phase_counter #(.W(CNT_W)) u_out_cnt (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (cnt_clr),
        .en_i   ((state_q == OUTPUT) && out_rdy),
        .last_i (out_num_q - CNT_W'(1)),
        .cnt_o  (out_cnt_unused),
        .tc_o   (out_tc)
    );

    // Iteration counter never reaches its wrap point: the last iteration
    // leaves COMPUTE for OUTPUT instead of incrementing.
    phase_counter #(.W(CNT_W)) u_iter_cnt (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (cnt_clr),
        .en_i   (iter_inc),
        .last_i (iter_num_q - CNT_W'(1)),
        .cnt_o  (iter_cnt),
        .tc_o   (iter_tc)
    );

    // ------------------------------------------------------------------
    // Phase FSM. iter_inc marks every re-entry into COMPUTE from a later
    // phase of the same iteration (including COMPUTE -> COMPUTE when both
    // TRANSMIT and SHIFT are skipped).
    // ------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        iter_inc = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    state_d = (load_num_q == '0) ? COMPUTE : LOAD;
                end
            end
            LOAD: begin
                if (din_pe_v && load_tc) begin
                    state_d = COMPUTE;
                end
            end
            COMPUTE: begin
                if (inst_tc) begin
                    if (iter_tc) begin
                        state_d = OUTPUT;
                    end else if (tx_num_q != '0) begin
                        state_d = TRANSMIT;
                    end else if (reg_num_q != '0) begin
                        state_d = SHIFT;
                    end else begin
                        iter_inc = 1'b1;
                    end
                end
            end
            TRANSMIT: begin
                if (tx_tc) begin
                    if (reg_num_q != '0) begin
                        state_d = SHIFT;
                    end else begin
                        state_d  = COMPUTE;
                        iter_inc = 1'b1;
                    end
                end
            end
            SHIFT: begin
                if (sh_tc) begin
                    state_d  = COMPUTE;
                    iter_inc = 1'b1;
                end
            end
            OUTPUT: begin
                if (out_rdy && out_tc) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (abort && (state_q != IDLE)) begin
            state_d  = IDLE;
            iter_inc = 1'b0;
        end
    end

    // done lines up with the first IDLE cycle after the last accepted beat.
    assign done_d = (state_q == OUTPUT) && out_rdy && out_tc && !abort;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            load_num_q <= CNT_W'(DEF_LOAD_NUM);
            inst_num_q <= IM_ADDR_W'(DEF_INST_NUM);
            tx_num_q   <= CNT_W'(DEF_TX_NUM);
            reg_num_q  <= CNT_W'(DEF_REG_NUM);
            out_num_q  <= CNT_W'(DEF_OUT_NUM);
            iter_num_q <= CNT_W'(DEF_ITER_NUM);
            cfg_err_q  <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            load_num_q <= load_num_d;
            inst_num_q <= inst_num_d;
            tx_num_q   <= tx_num_d;
            reg_num_q  <= reg_num_d;
            out_num_q  <= out_num_d;
            iter_num_q <= iter_num_d;
            cfg_err_q  <= cfg_err_d;
            done_q     <= done_d;
        end
    end

    // Moore phase valids decoded straight from the state register.
    assign busy     = (state_q != IDLE);
    assign load_v   = (state_q == LOAD);
    assign cmpt_v   = (state_q == COMPUTE);
    assign tx_v     = (state_q == TRANSMIT);
    assign shift_v  = (state_q == SHIFT);
    assign output_v = (state_q == OUTPUT);
    assign cfg_err  = cfg_err_q;
    assign done     = done_q;

endmodule

// File: tb/tb_pe_phase_seq.sv
// tb/tb_pe_phase_seq.sv - self-checking bench for pe_phase_seq against a run-trace reference model
module tb_pe_phase_seq;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cfg_v = 1'b0;
    logic [7:0] cfg_load_num = '0, cfg_inst_num = '0, cfg_tx_num = '0;
    logic [7:0] cfg_reg_num = '0, cfg_out_num = '0, cfg_iter_num = '0;
    logic       cfg_err;
    logic       start = 1'b0, abort = 1'b0, din_pe_v = 1'b0, out_rdy = 1'b0;
    logic       busy, load_v, cmpt_v, tx_v, shift_v, output_v, done;
    logic [7:0] inst_addr, iter_cnt;

    always #5 clk = ~clk;

    pe_phase_seq dut (
        .clk(clk), .rst(rst), .cfg_v(cfg_v),
        .cfg_load_num(cfg_load_num), .cfg_inst_num(cfg_inst_num), .cfg_tx_num(cfg_tx_num),
        .cfg_reg_num(cfg_reg_num), .cfg_out_num(cfg_out_num), .cfg_iter_num(cfg_iter_num),
        .cfg_err(cfg_err), .start(start), .abort(abort), .din_pe_v(din_pe_v), .out_rdy(out_rdy),
        .busy(busy), .load_v(load_v), .cmpt_v(cmpt_v), .tx_v(tx_v), .shift_v(shift_v),
        .output_v(output_v), .inst_addr(inst_addr), .iter_cnt(iter_cnt), .done(done)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference view of the DUT configuration.
    int m_load, m_inst, m_tx, m_reg, m_out, m_iter;
    bit m_err;

    // One entry per expected busy cycle: phase (0 idle,1 load,2 compute,3 tx,4 shift,5 output),
    // expected address/iteration, and the din/rdy values driven in that cycle.
    typedef struct {
        int ph;
        int addr;
        int iter;
        bit din;
        bit rdy;
    } ent_t;

    ent_t tr[$];
    bit   din_pat[$];
    bit   rdy_pat[$];

    task automatic model_defaults();
        m_load = 32; m_inst = 20; m_tx = 4; m_reg = 16; m_out = 4; m_iter = 4; m_err = 1'b0;
    endtask

    function automatic logic [23:0] observed();
        return {busy, load_v, cmpt_v, tx_v, shift_v, output_v, done, cfg_err, inst_addr, iter_cnt};
    endfunction

    // Beat patterns: exactly m_load din beats / m_out ready beats, each ending on a beat.
    task automatic gen_pats(input bit rnd_din, input bit rnd_rdy);
        bit b;
        int got;
        din_pat.delete();
        got = 0;
        while (got < m_load) begin
            b = rnd_din ? 1'($urandom_range(0, 1)) : 1'b1;
            din_pat.push_back(b);
            got += int'(b);
        end
        rdy_pat.delete();
        got = 0;
        while (got < m_out) begin
            b = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
            rdy_pat.push_back(b);
            got += int'(b);
        end
    endtask

    // Expand the current model config and beat patterns into a full run trace.
    task automatic build_trace();
        ent_t e;
        tr.delete();
        foreach (din_pat[k]) begin
            e.ph = 1; e.addr = 0; e.iter = 0; e.din = din_pat[k]; e.rdy = 1'($urandom_range(0, 1));
            tr.push_back(e);
        end
        for (int i = 0; i < m_iter; i++) begin
            for (int a = 0; a < m_inst; a++) begin
                e.ph = 2; e.addr = a; e.iter = i;
                e.din = 1'($urandom_range(0, 1)); e.rdy = 1'($urandom_range(0, 1));
                tr.push_back(e);
            end
            if (i < m_iter - 1) begin
                for (int t = 0; t < m_tx; t++) begin
                    e.ph = 3; e.addr = 0; e.iter = i;
                    e.din = 1'($urandom_range(0, 1)); e.rdy = 1'($urandom_range(0, 1));
                    tr.push_back(e);
                end
                for (int s = 0; s < m_reg; s++) begin
                    e.ph = 4; e.addr = 0; e.iter = i;
                    e.din = 1'($urandom_range(0, 1)); e.rdy = 1'($urandom_range(0, 1));
                    tr.push_back(e);
                end
            end
        end
        foreach (rdy_pat[k]) begin
            e.ph = 5; e.addr = 0; e.iter = m_iter - 1; e.din = 1'($urandom_range(0, 1)); e.rdy = rdy_pat[k];
            tr.push_back(e);
        end
    endtask

    // Config write issued from IDLE; the model applies the acceptance rules.
    task automatic cfg_write(input int ld, input int inst, input int tx, input int rg,
                             input int outn, input int it);
        @(negedge clk);
        cfg_load_num = 8'(ld); cfg_inst_num = 8'(inst); cfg_tx_num = 8'(tx);
        cfg_reg_num = 8'(rg); cfg_out_num = 8'(outn); cfg_iter_num = 8'(it);
        cfg_v = 1'b1;
        @(negedge clk);
        cfg_v = 1'b0;
        if (inst == 0 || it == 0 || outn == 0) begin
            m_err = 1'b1;
        end else begin
            m_load = ld; m_inst = inst; m_tx = tx; m_reg = rg; m_out = outn; m_iter = it; m_err = 1'b0;
        end
        n_tests++;
        if (cfg_err !== m_err) begin
            n_fail++;
            $display("FAIL cfg_err after write: got %b expected %b", cfg_err, m_err);
        end
    endtask

    // Start a run and walk the trace. cut >= 0 aborts (or resets) in that trace cycle.
    // cfg_at: -2 none, -1 with start, k during trace cycle k (must all be ignored).
    task automatic exec_trace(input string name, input int cut, input bit by_rst, input int cfg_at);
        logic [23:0] exp;
        @(negedge clk);
        start = 1'b1; din_pe_v = 1'b0; out_rdy = 1'b0;
        cfg_v = (cfg_at == -1);
        foreach (tr[k]) begin
            @(negedge clk);
            start = 1'b0; cfg_v = 1'b0;
            exp = {tr[k].ph != 0, tr[k].ph == 1, tr[k].ph == 2, tr[k].ph == 3, tr[k].ph == 4,
                   tr[k].ph == 5, 1'b0, m_err, 8'(tr[k].addr), 8'(tr[k].iter)};
            n_tests++;
            if (observed() !== exp) begin
                n_fail++;
                $display("FAIL %s cycle %0d: got %h expected %h", name, k, observed(), exp);
            end
            if (k == cut) begin
                if (by_rst) rst = 1'b1; else abort = 1'b1;
                din_pe_v = 1'($urandom_range(0, 1)); out_rdy = 1'($urandom_range(0, 1));
                @(negedge clk);
                rst = 1'b0; abort = 1'b0; din_pe_v = 1'b0; out_rdy = 1'b0;
                if (by_rst) model_defaults();
                exp = {7'b0, m_err, 16'h0};
                n_tests++;
                if (observed() !== exp) begin
                    n_fail++;
                    $display("FAIL %s stop: got %h expected %h", name, observed(), exp);
                end
                return;
            end
            din_pe_v = tr[k].din;
            out_rdy  = tr[k].rdy;
            if (k == cfg_at) cfg_v = 1'b1;
        end
        @(negedge clk);
        cfg_v = 1'b0; din_pe_v = 1'b0; out_rdy = 1'b0;
        exp = {6'b0, 1'b1, m_err, 16'h0};
        n_tests++;
        if (observed() !== exp) begin
            n_fail++;
            $display("FAIL %s done: got %h expected %h", name, observed(), exp);
        end
        @(negedge clk);
        exp = {7'b0, m_err, 16'h0};
        n_tests++;
        if (observed() !== exp) begin
            n_fail++;
            $display("FAIL %s post-done: got %h expected %h", name, observed(), exp);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_tests++;
        if (observed() !== 24'h0) begin
            n_fail++;
            $display("FAIL reset outputs: got %h expected %h", observed(), 24'h0);
        end
        rst = 1'b0;
        model_defaults();
        @(negedge clk);
        n_tests++;
        if (observed() !== 24'h0) begin
            n_fail++;
            $display("FAIL idle after reset: got %h expected %h", observed(), 24'h0);
        end
    endtask

    task automatic test_defaults();
        gen_pats(1'b0, 1'b0);
        build_trace();
        exec_trace("defaults", -1, 1'b0, -2);
    endtask

    task automatic test_load_gaps();
        cfg_write(3, 20, 4, 16, 4, 4);
        din_pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        rdy_pat = '{1'b1, 1'b1, 1'b1, 1'b1};
        build_trace();
        exec_trace("load_gaps", -1, 1'b0, -2);
    endtask

    task automatic test_skipping();
        cfg_write(0, 2, 0, 0, 1, 3);
        gen_pats(1'b0, 1'b0);
        build_trace();
        exec_trace("skipping", -1, 1'b0, -2);
    endtask

    task automatic test_backpressure();
        cfg_write(0, 3, 1, 1, 2, 2);
        rdy_pat = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        din_pat.delete();
        build_trace();
        exec_trace("backpressure", -1, 1'b0, -2);
    endtask

    task automatic test_config();
        cfg_write(2, 3, 1, 2, 2, 2);
        cfg_write(5, 0, 9, 9, 9, 9);
        cfg_write(5, 9, 9, 9, 9, 0);
        cfg_write(5, 9, 9, 9, 0, 9);
        // Junk values on the cfg bus during the run must not take effect.
        cfg_load_num = 8'd7; cfg_inst_num = 8'd7; cfg_tx_num = 8'd7;
        cfg_reg_num = 8'd7; cfg_out_num = 8'd7; cfg_iter_num = 8'd7;
        gen_pats(1'b1, 1'b0);
        build_trace();
        exec_trace("cfg_rejected_kept", -1, 1'b0, 4);
        gen_pats(1'b0, 1'b1);
        build_trace();
        exec_trace("cfg_with_start", -1, 1'b0, -1);
        cfg_write(1, 2, 0, 1, 1, 2);
        gen_pats(1'b0, 1'b0);
        build_trace();
        exec_trace("cfg_valid", -1, 1'b0, -2);
    endtask

    task automatic test_abort();
        cfg_write(32, 20, 4, 16, 4, 4);
        gen_pats(1'b0, 1'b0);
        build_trace();
        exec_trace("abort_compute", 32 + 10, 1'b0, -2);
        @(negedge clk);
        start = 1'b1; abort = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        n_tests++;
        if (observed() !== {7'b0, m_err, 16'h0}) begin
            n_fail++;
            $display("FAIL abort_idle: got %h expected %h", observed(), {7'b0, m_err, 16'h0});
        end
        build_trace();
        exec_trace("after_abort", -1, 1'b0, -2);
    endtask

    task automatic test_rst_mid();
        cfg_write(2, 3, 2, 5, 2, 3);
        gen_pats(1'b0, 1'b0);
        build_trace();
        exec_trace("rst_shift", 9, 1'b1, -2);
        gen_pats(1'b0, 1'b0);
        build_trace();
        exec_trace("after_rst_defaults", -1, 1'b0, -2);
    endtask

    task automatic test_boundary();
        cfg_write(0, 255, 255, 0, 1, 2);
        gen_pats(1'b0, 1'b0);
        build_trace();
        exec_trace("max_inst_tx", -1, 1'b0, -2);
        cfg_write(255, 1, 0, 0, 255, 1);
        gen_pats(1'b0, 1'b0);
        build_trace();
        exec_trace("max_load_out", -1, 1'b0, -2);
    endtask

    task automatic test_random();
        int inst;
        for (int r = 0; r < 12; r++) begin
            inst = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 5);
            cfg_write($urandom_range(0, 6), inst, $urandom_range(0, 3), $urandom_range(0, 3),
                      $urandom_range(1, 4), $urandom_range(1, 4));
            cfg_load_num = 8'($urandom); cfg_inst_num = 8'($urandom); cfg_tx_num = 8'($urandom);
            cfg_reg_num = 8'($urandom); cfg_out_num = 8'($urandom); cfg_iter_num = 8'($urandom);
            gen_pats(1'b1, 1'b1);
            build_trace();
            exec_trace("random", -1, 1'b0, $urandom_range(0, tr.size()) - 2);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_defaults();
        test_load_gaps();
        test_skipping();
        test_backpressure();
        test_config();
        test_abort();
        test_rst_mid();
        test_boundary();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pe_phase_seq.md
Name: pe_phase_seq

Overview:
- Parametrised, runtime-configurable phase sequencer for a PE: IDLE, LOAD, COMPUTE, TRANSMIT, SHIFT, OUTPUT.
- Generates the phase valids, instruction-ROM address and iteration count that drive the PE's IMEM, DMEM and ALU.
- Over the fixed-count predecessor it adds:
  - per-run configurable phase lengths, with zero-length phase skipping;
  - beat-counted LOAD, so gaps in the input stream are allowed;
  - OUTPUT backpressure;
  - abort;
  - done and config-error reporting.

Parameters:
CNT_W, 8, width of all phase counters and cfg count fields
IM_ADDR_W, 8, instruction address width
DEF_LOAD_NUM, 32, reset value of load count
DEF_INST_NUM, 20, reset value of instructions per iteration
DEF_TX_NUM, 4, reset value of transmit cycles
DEF_REG_NUM, 16, reset value of shift cycles
DEF_OUT_NUM, 4, reset value of output beats
DEF_ITER_NUM, 4, reset value of iterations per run

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
cfg_v  in  1  config write strobe
cfg_load_num  in  CNT_W  load beats per run
cfg_inst_num  in  IM_ADDR_W  instructions per iteration
cfg_tx_num  in  CNT_W  transmit cycles per iteration
cfg_reg_num  in  CNT_W  shift cycles per iteration
cfg_out_num  in  CNT_W  output beats per run
cfg_iter_num  in  CNT_W  iterations per run
cfg_err  out  1  sticky: last cfg write rejected
start  in  1  begin run (sampled in IDLE only)
abort  in  1  abandon run, return to IDLE
din_pe_v  in  1  load-data beat valid
out_rdy  in  1  downstream ready for output beats
busy  out  1  state != IDLE
load_v  out  1  in LOAD
cmpt_v  out  1  in COMPUTE
tx_v  out  1  in TRANSMIT
shift_v  out  1  in SHIFT
output_v  out  1  in OUTPUT
inst_addr  out  IM_ADDR_W  current instruction address
iter_cnt  out  CNT_W  completed iterations in this run
done  out  1  one-cycle pulse on normal run completion

Behaviour:
- Interface: reset rst, synchronous, active-high; clock clk.
- Reset: state IDLE; all outputs 0; config registers take the DEF_* values; cfg_err 0.
- Phase valids are Moore outputs decoded from the state register, so each valid is high exactly in the cycles its state is held. inst_addr, iter_cnt, done and cfg_err are registered.
- Config write:
  - Accepted only in IDLE when start is not asserted in the same cycle.
  - cfg_v outside IDLE is ignored and leaves cfg_err unchanged.
  - A write with cfg_inst_num, cfg_iter_num or cfg_out_num equal to 0 is rejected: registers are unchanged and cfg_err is set.
  - A valid write clears cfg_err.
- IDLE, on start:
  - load_num=0: go to COMPUTE.
  - Otherwise: go to LOAD.
  - cfg_v in the same cycle is ignored.
- LOAD:
  - The counter increments only on cycles with din_pe_v=1.
  - On the load_num-th beat, go to COMPUTE next cycle.
  - No timeout.
- COMPUTE:
  - Lasts exactly inst_num cycles.
  - inst_addr is 0 on the first cycle and increments each cycle, reaching inst_num-1.
  - On exit inst_addr returns to 0.
- After COMPUTE:
  - iter_cnt==iter_num-1: go to OUTPUT.
  - Else tx_num!=0: go to TRANSMIT.
  - Else reg_num!=0: go to SHIFT.
  - Else: go to COMPUTE, with iter_cnt+1.
- TRANSMIT: tx_num cycles. Then SHIFT if reg_num!=0, else COMPUTE.
- SHIFT: reg_num cycles, then COMPUTE.
- iter_cnt:
  - Increments by 1 on every transition back into COMPUTE.
  - Cleared on entry to IDLE.
  - Counts 0..iter_num-1 during a run.
- OUTPUT:
  - output_v is held high; a beat transfers only when output_v and out_rdy are both 1.
  - After the out_num-th transfer: go to IDLE and pulse done for 1 cycle, coincident with the first IDLE cycle.
  - out_rdy low stalls OUTPUT indefinitely.
- abort:
  - In any non-IDLE state, next state is IDLE.
  - All counters clear, done is not pulsed, config is retained.
  - abort in IDLE has no effect and overrides start.
  - rst mid-run behaves the same except config returns to the DEF_* values.
- Counter width: all counters are CNT_W wide and compare against count-1, so a count of 2^CNT_W-1 is the maximum. There is no wrap-around within a phase.

Decomposition:
- Shared package/header holds:
  - state encodings (3-bit localparams IDLE=0, LOAD=1, COMPUTE=2, TRANSMIT=3, SHIFT=4, OUTPUT=5);
  - the DEF_* count constants alongside the existing phase-count defines.
- One natural sub-module: phase_counter, a CNT_W counter with enable, clear and a terminal-count compare against a programmable count-1. Instantiated once per phase.
- FSM and config registers stay in the top level.

Test Plan:
- Defaults: start, 32 consecutive din_pe_v → exactly 4 iterations each of 20 cmpt_v / 4 tx_v / 16 shift_v cycles. The last iteration goes COMPUTE→OUTPUT, 4 output_v beats with out_rdy=1, then done pulses; iter_cnt seen 0..3.
- LOAD gaps: load_num=3, din_pe_v pattern 1,0,0,1,0,1 → LOAD holds 6 cycles; cmpt_v rises the cycle after the 3rd beat; inst_addr steps 0..19.
- Skipping: cfg tx_num=0, reg_num=0, iter_num=3, inst_num=2 → cmpt_v high for 6 consecutive cycles; inst_addr sequence 0,1,0,1,0,1; no tx_v or shift_v.
- Backpressure: out_num=2, out_rdy toggling 0,1,0,0,1 → output_v high 5 cycles; done only after the 2nd accepted beat.
- Config rules: cfg_v with inst_num=0 → cfg_err=1 and old values kept. cfg_v during COMPUTE → ignored. Valid cfg_v in IDLE → cfg_err=0.
- Abort/reset: abort at cycle 10 of COMPUTE → IDLE next cycle, inst_addr=0, iter_cnt=0, no done. A following start with defaults runs a full run correctly; rst mid-SHIFT restores DEF_* config.
